// File: rtl/lc3_io_pkg.sv
`default_nettype none
//==============================================================================
// Module : lc3_io_pkg
// Brief  : Shared types and constants for the LC-3 display/serial path.
// Rev    : 1.0 - initial release
//==============================================================================
package lc3_io_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_t;

  localparam int   UART_DATA_BITS  = 8;
  localparam logic UART_IDLE_LEVEL = 1'b1;

  function automatic logic even_parity(input logic [UART_DATA_BITS-1:0] i_byte);
    return ^i_byte;
  endfunction

endpackage
`default_nettype wire

// File: rtl/lc3_baud_tick.sv
`default_nettype none
//==============================================================================
// Module : lc3_baud_tick
// Brief  : Bit-period counter; o_Tick pulses on the last cycle of each period.
// Rev    : 1.0 - initial release
//==============================================================================
module lc3_baud_tick #(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic i_Clk,
  input  logic i_Rst_n,
  input  logic i_Clr,
  output logic o_Tick
);

  localparam int c_CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(CLKS_PER_BIT - 1);

  logic [c_CNT_W-1:0] r_baud_cnt;
  logic               w_last;

  assign w_last = (r_baud_cnt == c_LAST);
  assign o_Tick = w_last;

  // A clear restarts the period so the first bit is a full CLKS_PER_BIT long.
  always_ff @(posedge i_Clk) begin
    if (!i_Rst_n || i_Clr) begin
      r_baud_cnt <= '0;
    end else if (w_last) begin
      r_baud_cnt <= '0;
    end else begin
      r_baud_cnt <= r_baud_cnt + 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/lc3_uart_tx.sv
`default_nettype none
//==============================================================================
// Module : lc3_uart_tx
// Brief  : 8N1 (8E1 with LC3_UART_TX_PARITY_EN) transmitter started by a falling
//          edge on i_Send; o_Ready stays low for the whole frame.
// Rev    : 1.0 - initial release
//==============================================================================
module lc3_uart_tx
  import lc3_io_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic        i_Clk,
  input  logic        i_Rst_n,
  input  logic        i_Send,
  input  logic [15:0] i_Data,
  output logic        o_Ready,
  output logic        o_Tx
);

  localparam logic [2:0] c_LAST_BIT = 3'(UART_DATA_BITS - 1);

  tx_state_t                 r_state;
  logic [UART_DATA_BITS-1:0] r_shreg;
  logic [2:0]                r_bit_idx;
  logic                      r_send_q;
  logic                      r_tx;
  logic                      r_ready;
`ifdef LC3_UART_TX_PARITY_EN
  logic                      r_parity;
`endif

  logic w_start;
  logic w_accept;
  logic w_tick;
  logic w_unused_data;

  assign w_start       = r_send_q & ~i_Send;
  assign w_accept      = w_start & (r_state == IDLE);
  assign w_unused_data = ^i_Data[15:UART_DATA_BITS];

  lc3_baud_tick #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_baud_tick (
    .i_Clk   (i_Clk),
    .i_Rst_n (i_Rst_n),
    .i_Clr   (w_accept),
    .o_Tick  (w_tick)
  );

  // The line level for the next state is loaded on the transition edge so
  // o_Tx always comes straight from a flop.
  always_ff @(posedge i_Clk) begin
    if (!i_Rst_n) begin
      r_state   <= IDLE;
      r_shreg   <= '0;
      r_bit_idx <= '0;
      r_send_q  <= 1'b1;
      r_tx      <= UART_IDLE_LEVEL;
      r_ready   <= 1'b1;
`ifdef LC3_UART_TX_PARITY_EN
      r_parity  <= 1'b0;
`endif
    end else begin
      r_send_q <= i_Send;
      case (r_state)
        IDLE: begin
          r_tx    <= UART_IDLE_LEVEL;
          r_ready <= 1'b1;
          if (w_start) begin
            r_shreg   <= i_Data[UART_DATA_BITS-1:0];
            r_bit_idx <= '0;
            r_state   <= START;
            r_tx      <= 1'b0;
            r_ready   <= 1'b0;
`ifdef LC3_UART_TX_PARITY_EN
            r_parity  <= even_parity(i_Data[UART_DATA_BITS-1:0]);
`endif
          end
        end
        START: begin
          if (w_tick) begin
            r_state <= DATA;
            r_tx    <= r_shreg[0];
          end
        end
        DATA: begin
          if (w_tick) begin
            r_shreg <= {1'b0, r_shreg[UART_DATA_BITS-1:1]};
            if (r_bit_idx == c_LAST_BIT) begin
`ifdef LC3_UART_TX_PARITY_EN
              r_state <= PARITY;
              r_tx    <= r_parity;
`else
              r_state <= STOP;
              r_tx    <= UART_IDLE_LEVEL;
`endif
            end else begin
              r_bit_idx <= r_bit_idx + 3'd1;
              r_tx      <= r_shreg[1];
            end
          end
        end
`ifdef LC3_UART_TX_PARITY_EN
        PARITY: begin
          if (w_tick) begin
            r_state <= STOP;
            r_tx    <= UART_IDLE_LEVEL;
          end
        end
`endif
        STOP: begin
          if (w_tick) begin
            r_state <= IDLE;
            r_tx    <= UART_IDLE_LEVEL;
            r_ready <= 1'b1;
          end
        end
        default: begin
          r_state <= IDLE;
          r_tx    <= UART_IDLE_LEVEL;
          r_ready <= 1'b1;
        end
      endcase
    end
  end

  assign o_Tx    = r_tx;
  assign o_Ready = r_ready;

endmodule
`default_nettype wire

// File: tb/tb_lc3_uart_tx.sv
`default_nettype none
//==============================================================================
// Module : tb_lc3_uart_tx
// Brief  : Scoreboard bench for lc3_uart_tx with CLKS_PER_BIT = 4.
// Rev    : 1.0 - initial release
//==============================================================================
module tb_lc3_uart_tx;

  localparam int C = 4;
`ifdef LC3_UART_TX_PARITY_EN
  localparam bit PAR = 1'b1;
  localparam int NB  = 11;
`else
  localparam bit PAR = 1'b0;
  localparam int NB  = 10;
`endif

  logic        clk;
  logic        rst_n;
  logic        send;
  logic [15:0] data;
  logic        o_Ready;
  logic        o_Tx;

  lc3_uart_tx #(.CLKS_PER_BIT(C)) dut (
    .i_Clk   (clk),
    .i_Rst_n (rst_n),
    .i_Send  (send),
    .i_Data  (data),
    .o_Ready (o_Ready),
    .o_Tx    (o_Tx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct packed {
    logic [7:0]  d;
    logic [31:0] e;
  } exp_t;

  exp_t        q[$];
  int          checks = 0;
  int          errors = 0;
  int unsigned busy_end = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Expected line level during cycle slot k of a frame carrying byte d.
  function automatic logic frame_level(input logic [7:0] d, input int k);
    if (k == 0) return 1'b0;
    if (k <= 8) return 1'((d >> (k - 1)) & 8'd1);
    if (PAR && k == 9) return 1'(($countones(d) % 2) == 1);
    return 1'b1;
  endfunction

  // Called at a negedge: raise send for one edge, then drop it. The model
  // accepts the request only if the previous frame's busy window has closed.
  task automatic send_byte(input logic [15:0] d, output int unsigned e);
    data = d;
    send = 1'b1;
    @(negedge clk);
    send = 1'b0;
    e = cyc + 1;
    if (e >= busy_end) begin
      q.push_back('{d: d[7:0], e: e});
      busy_end = e + NB * C + 1;
    end
  endtask

  task automatic wait_edge(input int unsigned target);
    while (cyc + 2 < target) @(negedge clk);
  endtask

  // ---------------- monitor ----------------
  logic        prev_ready = 1'b1;
  bit          cap = 1'b0;
  bit          cap_skip = 1'b0;
  int          cap_idx;
  int          nbad_tx;
  int          nbad_rdy;
  logic [7:0]  cap_d;

  always @(negedge clk) begin
    exp_t x;
    if (rst_n !== 1'b1) begin
      cap = 1'b0;
    end else begin
      if (!cap && prev_ready === 1'b1 && o_Ready === 1'b0) begin
        cap      = 1'b1;
        cap_idx  = 0;
        nbad_tx  = 0;
        nbad_rdy = 0;
        if (q.size() == 0) begin
          cap_skip = 1'b1;
          chk("unexpected_frame", 32'd1, 32'd0);
        end else begin
          cap_skip = 1'b0;
          x = q.pop_front();
          cap_d = x.d;
          chk("start_cycle", cyc, x.e);
        end
      end
      if (cap) begin
        if (cap_idx < NB * C) begin
          if (o_Tx !== frame_level(cap_d, cap_idx / C)) nbad_tx++;
          if (o_Ready !== 1'b0) nbad_rdy++;
          cap_idx++;
        end else begin
          cap = 1'b0;
          if (!cap_skip) begin
            chk("frame_tx_bad_cycles", nbad_tx, 0);
            chk("busy_bad_cycles", nbad_rdy, 0);
            chk("ready_after_frame", {31'd0, o_Ready}, 1);
          end
        end
      end else if (o_Ready === 1'b1) begin
        chk("idle_tx", {31'd0, o_Tx}, 1);
      end
    end
    prev_ready = o_Ready;
  end

  // ---------------- stimulus ----------------
  initial begin
    int unsigned e;
    int unsigned t;
    int          mode;
    rst_n = 1'b0;
    send  = 1'b0;
    data  = 16'h0000;

    // Reset held with send low; release together with send high so the
    // restored send_q does not see a falling edge.
    repeat (3) @(negedge clk);
    chk("reset_tx", {31'd0, o_Tx}, 1);
    chk("reset_ready", {31'd0, o_Ready}, 1);
    rst_n = 1'b1;
    send  = 1'b1;
    repeat (20) @(negedge clk);
    chk("no_frame_after_reset", {31'd0, o_Ready}, 1);

    // Single known byte.
    send_byte(16'h1241, e);
    wait_edge(busy_end + 2);

    // Send held low for 100 cycles: one frame only.
    send_byte(16'($urandom), e);
    repeat (100) @(negedge clk);
    wait_edge(busy_end + 2);

    // Second request at frame cycle 12 is ignored; data changes mid-frame.
    send_byte(16'($urandom), e);
    wait_edge(e + 12);
    send_byte(16'($urandom), t);
    repeat (8) @(negedge clk);
    data = 16'($urandom);
    wait_edge(busy_end + 1);

    // Reset at cycle 20 of a frame, then a clean frame.
    send_byte(16'($urandom), e);
    while (cyc < e + 19) @(negedge clk);
    rst_n = 1'b0;
    send  = 1'b1;
    @(negedge clk);
    chk("midreset_tx", {31'd0, o_Tx}, 1);
    chk("midreset_ready", {31'd0, o_Ready}, 1);
    rst_n = 1'b1;
    busy_end = 0;
    @(negedge clk);
    send_byte(16'($urandom), e);
    wait_edge(busy_end + 2);

    // Randomised traffic: back-to-back, short gaps and ignored busy requests.
    for (int i = 0; i < 40; i++) begin
      mode = int'($urandom_range(0, 2));
      if (mode == 0) t = busy_end;
      else if (mode == 1) t = busy_end + $urandom_range(1, 6);
      else t = busy_end - $urandom_range(2, 35);
      wait_edge(t);
      send_byte(16'($urandom), e);
      if ($urandom_range(0, 1) == 1) begin
        @(negedge clk);
        data = 16'($urandom);
      end
    end

    wait_edge(busy_end + 4);
    for (int k = 0; k < 200 && (q.size() != 0 || cap); k++) @(negedge clk);
    chk("scoreboard_drained", q.size(), 0);
    chk("monitor_idle", {31'd0, cap}, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/lc3_uart_tx.md
# lc3_uart_tx

Serial transmitter for the LC-3 display path. It sits directly downstream of the display output controller. A falling edge on that controller's `send` strobe makes this block capture the low byte of the display data register and shift it out as an 8N1 UART frame. It holds `ready` low for the whole frame, which is the signal the controller waits on before pulsing its status-register load.

## Interface
- `CLKS_PER_BIT`, default 868: clock cycles per serial bit (100 MHz / 115200 baud); legal range ≥ 2.
- `i_Clk`, input, 1: system clock; all logic is on the rising edge.
- `i_Rst_n`, input, 1: reset, synchronous and active-low.
- `i_Send`, input, 1: start request; a high-to-low transition starts a frame.
- `i_Data`, input, 16: display data register; only bits [7:0] are transmitted.
- `o_Ready`, output, 1: high when idle and able to accept a frame.
- `o_Tx`, output, 1: serial line; idles high.

## Operation
- Edge detect:
  - `send_q` is a registered copy of `i_Send`, reset to 1.
  - `start = send_q & ~i_Send`.
  - A level held low never retriggers a frame.
- States (encoding held in the package): IDLE, START, DATA, STOP (plus PARITY, see Configuration).
  - IDLE: `o_Tx`=1, `o_Ready`=1. On `start`:
    - latch `i_Data[7:0]` into `shreg`;
    - clear `baud_cnt` and `bit_idx`;
    - go to START.
  - START: `o_Tx`=0 for CLKS_PER_BIT cycles, then go to DATA.
  - DATA: `o_Tx`=`shreg[0]`.
    - Every CLKS_PER_BIT cycles: shift `shreg` right and increment `bit_idx`.
    - After bit 7 completes, go to STOP (or PARITY).
    - Bits are sent LSB first.
  - STOP: `o_Tx`=1 for CLKS_PER_BIT cycles, then go to IDLE.
- `o_Ready` = (state == IDLE), driven as a registered output.
- `baud_cnt` counts 0..CLKS_PER_BIT-1 and wraps. A bit period ends when `baud_cnt` == CLKS_PER_BIT-1.
- Counter widths:
  - `baud_cnt` is $clog2(CLKS_PER_BIT) bits.
  - `bit_idx` is 3 bits; the transition is taken at `bit_idx`==7 with the period ending, so there is no wrap.
- A `start` while not in IDLE is ignored, and no pending request is stored.
- Changes on `i_Data` after the latch cycle do not affect the frame in flight.
- Reset low at any edge, including mid-frame:
  - state goes to IDLE, `o_Tx` to 1 and `o_Ready` to 1;
  - counters clear and `send_q` goes to 1;
  - takes effect at that edge.

## Timing
- Reset values: `o_Tx`=1, `o_Ready`=1, state IDLE, `shreg`=0, `send_q`=1.
- Start latency: if `i_Send` falls before edge N, then at edge N `start` is true and the block enters START. From edge N:
  - `o_Tx` is 0;
  - `o_Ready` is 0.
- The controller's sequence (send low, next cycle poll ready) therefore always sees `ready`=0 first.
- Frame timing:
  - `o_Ready` is low for exactly 10×CLKS_PER_BIT cycles (11× with parity), then high.
  - The start bit begins on the same edge that `o_Ready` falls.
- Back-to-back frames: a new falling edge in the first IDLE cycle starts the next frame. The minimum IDLE gap is 1 cycle.
- `o_Tx` is glitch-free because it is driven from a flop.

## Configuration
- `LC3_UART_TX_PARITY_EN`:
  - Defined: the PARITY state is inserted between DATA and STOP. It drives `o_Tx` = even parity (XOR of the latched byte, computed at latch time) for one bit period. The frame becomes 8E1 and busy time becomes 11×CLKS_PER_BIT.
  - Undefined: there is no PARITY state or parity flop, and the frame is 8N1.

## Structure
- The shared package `lc3_io_pkg` holds:
  - the `tx_state_t` enum (IDLE, START, DATA, PARITY, STOP);
  - the constants `UART_DATA_BITS`=8 and `UART_IDLE_LEVEL`=1'b1.
- One sub-module, `lc3_baud_tick`:
  - parameter CLKS_PER_BIT;
  - inputs `i_Clk`, `i_Rst_n`, `i_Clr`;
  - output `o_Tick`, a one-cycle pulse at the end of each bit period;
  - `i_Clr` is asserted by the FSM on `start`.

## Test plan
All scenarios use CLKS_PER_BIT=4.
- Reset: hold `i_Rst_n`=0 for 3 cycles with `i_Send`=0 -> `o_Tx`=1, `o_Ready`=1, and no frame starts after release.
- Single byte: `i_Data`=16'h1241, then `i_Send` 1→0 -> `o_Ready` is 0 for 40 cycles. `o_Tx` runs 0, 1,0,0,0,0,0,1,0, 1, each bit held 4 cycles.
- Held-low send: `i_Send` stays 0 for 100 cycles after the 1→0 edge -> exactly one frame is sent.
- Busy and data changes:
  - a second 1→0 edge at cycle 12 of the frame is ignored;
  - `i_Data` changed mid-frame does not alter the serial bits.
- Mid-frame reset: reset asserted at cycle 20 of a frame ->
  - `o_Tx`=1 and `o_Ready`=1 at the next edge;
  - a following send yields a clean full frame.
- Parity build with `LC3_UART_TX_PARITY_EN`: byte 8'h07 -> parity bit 1 after bit 7, and `o_Ready` is low for 44 cycles.
